imem_loader: RTL

- Writer side of the instruction memory. Receives a program as a byte stream over a valid/ready handshake and packs each 4 bytes into one 32-bit word.
- Issues one word write per word into the instruction RAM, starting at word address 0.
- Holds the CPU in reset while loading is in progress.
- Sits between the boot/UART byte source and the instruction RAM write port. This replaces the file-based preload.

---
 rtl/imem_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words
// and writes them to the instruction RAM from word address 0, holding the CPU
// in reset for the duration of the load.
module imem_loader #(
   parameter int unsigned N = 32,
   parameter int unsigned R = 7
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [R:0]   len_words,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic         mem_we,
   output logic [R-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         busy,
   output logic         done,
   output logic         cpu_hold
);

   typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

   // Largest loadable image: one full memory (2^R words).
   localparam logic [R:0] MaxLen  = {1'b1, {R{1'b0}}};
   localparam logic [R:0] WordOne = {{R{1'b0}}, 1'b1};

   state_e       r_state, w_state_next;
   logic [1:0]   r_byte_cnt, w_byte_cnt_next;
   logic [R:0]   r_word_cnt, w_word_cnt_next;
   logic [R:0]   r_len, w_len_next;
   logic [N-1:0] r_shift, w_shift_next;
   logic [R-1:0] r_mem_addr, w_mem_addr_next;
   logic [N-1:0] r_mem_wdata, w_mem_wdata_next;

   logic [R:0]   w_len_clamped;
   logic [N-1:0] w_shift_in;
   logic [R:0]   w_word_cnt_inc;

   assign w_len_clamped  = (len_words > MaxLen) ? MaxLen : len_words;
   assign w_shift_in     = {r_shift[N-9:0], in_data};
   assign w_word_cnt_inc = r_word_cnt + WordOne;

   // State, counters and the registered RAM write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_byte_cnt  <= '0;
         r_word_cnt  <= '0;
         r_len       <= '0;
         r_shift     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state     <= w_state_next;
         r_byte_cnt  <= w_byte_cnt_next;
         r_word_cnt  <= w_word_cnt_next;
         r_len       <= w_len_next;
         r_shift     <= w_shift_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
      end
   end

   // Next-state logic: receive four bytes, write one word, repeat until len words.
   always_comb begin
      w_state_next     = r_state;
      w_byte_cnt_next  = r_byte_cnt;
      w_word_cnt_next  = r_word_cnt;
      w_len_next       = r_len;
      w_shift_next     = r_shift;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               if (len_words == '0) begin
                  w_state_next = StDone;
               end else begin
                  w_len_next      = w_len_clamped;
                  w_byte_cnt_next = '0;
                  w_word_cnt_next = '0;
                  w_shift_next    = '0;
                  w_state_next    = StRecv;
               end
            end
         end
         StRecv: begin
            if (in_valid) begin
               w_shift_next    = w_shift_in;
               w_byte_cnt_next = r_byte_cnt + 2'd1;
               // Fourth byte completes the word; latch the write port for next cycle.
               if (r_byte_cnt == 2'd3) begin
                  w_mem_addr_next  = r_word_cnt[R-1:0];
                  w_mem_wdata_next = w_shift_in;
                  w_state_next     = StWrite;
               end
            end
         end
         StWrite: begin
            w_word_cnt_next = w_word_cnt_inc;
            w_state_next    = (w_word_cnt_inc == r_len) ? StDone : StRecv;
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Outputs decoded from the state; address/data come straight from registers.
   always_comb begin
      in_ready  = (r_state == StRecv);
      mem_we    = (r_state == StWrite);
      busy      = (r_state == StRecv) || (r_state == StWrite);
      done      = (r_state == StDone);
      cpu_hold  = busy;
      mem_addr  = r_mem_addr;
      mem_wdata = r_mem_wdata;
   end

endmodule
